// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, state encoding and op-decoding helpers for muldiv_unit.
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_mul(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_divu(input logic [1:0] op);
    return op == MD_DIVU;
  endfunction

endpackage

// File: rtl/muldiv_unit_md_sign_fix.sv
// Conditional two's-complement negation: operand magnitudes on entry,
// product / quotient / remainder sign restoration on exit.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic         wide_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [2*W-1:0] cat;
  logic [2*W-1:0] cat_neg;

  // wide_i: {hi,lo} is a single 2W value negated under neg_lo_i.
  always_comb begin
    cat     = {hi_i, lo_i};
    cat_neg = '0 - cat;
    hi_o    = hi_i;
    lo_o    = lo_i;
    if (wide_i) begin
      if (neg_lo_i) begin
        hi_o = cat_neg[2*W-1:W];
        lo_o = cat_neg[W-1:0];
      end
    end else begin
      if (neg_hi_i) hi_o = '0 - hi_i;
      if (neg_lo_i) lo_o = '0 - lo_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi, lo} for HILO.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one cycle on the native multiplier.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER   = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        md_op,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  input  logic              flush,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  md_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mul_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   opnd_q;
  logic                neg_q_q;
  logic                neg_r_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                valid_q;
  logic                busy_q;

  logic                in_signed;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ok;
  logic [DATA_W-1:0]   rem_d;
  logic [2*DATA_W-1:0] acc_d;
  logic                div_zero;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  assign in_signed = md_is_signed(md_op);

  md_sign_fix #(.W(DATA_W)) u_fix_in (
    .wide_i   (1'b0),
    .neg_hi_i (in_signed & num1[DATA_W-1]),
    .neg_lo_i (in_signed & num2[DATA_W-1]),
    .hi_i     (num1),
    .lo_i     (num2),
    .hi_o     (mag1),
    .lo_o     (mag2)
  );

  // acc_q = {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[DATA_W];
    rem_d     = div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    if (mul_q) acc_d = {mul_sum, acc_q[DATA_W-1:1]};
    else       acc_d = {rem_d, acc_q[DATA_W-2:0], div_ok};
  end

  // Zero divisor yields all-ones quotient; remainder sign fix restores num1.
  assign div_zero = ~mul_q & (opnd_q == '0);

  md_sign_fix #(.W(DATA_W)) u_fix_out (
    .wide_i   (mul_q),
    .neg_hi_i (neg_r_q),
    .neg_lo_i (neg_q_q & ~div_zero),
    .hi_i     (acc_d[2*DATA_W-1:DATA_W]),
    .lo_i     (acc_d[DATA_W-1:0]),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;

  always_comb begin
    if (in_signed)
      fast_prod = $signed({{DATA_W{num1[DATA_W-1]}}, num1}) *
                  $signed({{DATA_W{num2[DATA_W-1]}}, num2});
    else
      fast_prod = {{DATA_W{1'b0}}, num1} * {{DATA_W{1'b0}}, num2};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start && !flush) begin
            mul_q   <= md_is_mul(md_op);
            cnt_q   <= '0;
            neg_q_q <= in_signed & (num1[DATA_W-1] ^ num2[DATA_W-1]);
            neg_r_q <= in_signed & num1[DATA_W-1];
            busy_q  <= 1'b1;
            if (md_is_mul(md_op)) begin
              acc_q  <= {{DATA_W{1'b0}}, mag2};
              opnd_q <= mag1;
            end else begin
              acc_q  <= {{DATA_W{1'b0}}, mag1};
              opnd_q <= mag2;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (md_is_mul(md_op)) begin
              hi_q    <= fast_prod[2*DATA_W-1:DATA_W];
              lo_q    <= fast_prod[DATA_W-1:0];
              valid_q <= 1'b1;
              state_q <= MD_DONE;
            end else begin
              state_q <= MD_CALC;
            end
`else
            state_q <= MD_CALC;
`endif
          end
        end
        MD_CALC: begin
          if (flush) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              valid_q <= 1'b1;
              state_q <= MD_DONE;
            end
          end
        end
        MD_DONE: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stall        = ((state_q == MD_IDLE) & start & ~flush) | (state_q == MD_CALC);
  assign result_valid = valid_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int n_vec = 0;
  int n_mis = 0;
  logic [63:0] last_res = '0;

  muldiv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .md_op        (md_op),
    .num1         (num1),
    .num2         (num2),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (op[1] == 1'b0) return 1;
`endif
    return 33;
  endfunction

  // Cycle n is the n-th cycle after the edge that samples start.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int lat;
    int anomalies;
    int seen_at;
    exp = model(op, a, b);
    lat = latency(op);
    anomalies = 0;
    seen_at = -1;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; num1 = a; num2 = b;
    #1;
    check({tag, ".stall_start"}, {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 2'($urandom); num1 = $urandom; num2 = $urandom;
    #1;
    for (int n = 1; n <= lat + 3; n++) begin
      if (n > 1) begin
        @(posedge clk); #2;
      end
      if (result_valid === 1'b1 && seen_at < 0) seen_at = n;
      if (n < lat && (stall !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b1)) anomalies++;
      if (n == lat) begin
        check({tag, ".stall_done"}, {63'd0, stall}, 64'd0);
        check({tag, ".result"}, {hi, lo}, exp);
      end
      if (n == lat + 1) begin
        check({tag, ".pulse_end"}, {62'd0, result_valid, busy}, 64'd0);
      end
    end
    check({tag, ".latency"}, 64'(seen_at), 64'(lat));
    check({tag, ".busy_stall"}, 64'(anomalies), 64'd0);
    last_res = exp;
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] edges [4];

    rst = 1'b1; start = 1'b0; md_op = 2'b00; num1 = '0; num2 = '0; flush = 1'b0;
    #3;
    check("reset.outputs", {hi, lo}, 64'd0);
    check("reset.flags", {61'd0, result_valid, busy, stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3_5");
    run_op(2'b11, 32'd5, 32'd0, "divu_by0");
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, "div_neg5_by0");
    check("tb.div_neg5_by0_const", last_res, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // Flush in CALC cycle 10: abandoned, outputs retain the previous result.
    @(posedge clk); #1;
    start = 1'b1; md_op = 2'b11; num1 = 32'd1000; num2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush.after", {61'd0, stall, busy, result_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (result_valid === 1'b1) seen++;
    end
    check("flush.no_valid", 64'(seen), 64'd0);
    check("flush.hold", {hi, lo}, last_res);
    run_op(2'b11, 32'd1000, 32'd3, "after_flush");

    // start together with flush in IDLE is ignored.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; md_op = 2'b01; num1 = 32'd9; num2 = 32'd9;
    #1;
    check("idle_flush.stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush.busy", {63'd0, busy}, 64'd0);

    // Reset mid-CALC clears everything immediately.
    @(posedge clk); #1;
    start = 1'b1; md_op = 2'b10; num1 = 32'h1234_5678; num2 = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.hilo", {hi, lo}, 64'd0);
    check("rst_mid.flags", {62'd0, busy, stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFF_FFFF; edges[3] = 32'h8000_0000;
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 30);
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", k, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
